adc_frame_capture: RTL and testbench
====================================

Name: adc_frame_capture

Overview:
Receive-path capture stage between the 8-bit ADC input and the Ethernet packetizer.
- On a start pulse from the controller, waits for the ADC enable and discards the ADC pipeline-latency samples.
- Stores one frame of samples in an internal single-port-write / registered-read RAM.
- Streams the frame out over a valid/ready byte interface and pulses a completion flag back to the controller.
- Runs entirely in the ADC sample clock domain.

Parameters:
DATA_W, 8, sample width in bits.
FRAME_LEN, 1024, maximum samples per frame.
ADDR_W, 10, RAM address width; log2(FRAME_LEN).
SKIP, 4, samples discarded after en_adc rises (ADC pipeline latency).

Ports:
clk_32  in  1  ADC sample clock; all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  single-cycle request to capture one frame; ignored unless state is IDLE.
en_adc  in  1  level; capture window from controller.
addata  in  DATA_W  ADC sample, valid every cycle.
out_data  out  DATA_W  streamed sample.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts when out_valid & out_ready.
out_last  out  1  marks final byte of frame, qualified by out_valid.
frame_len  out  ADDR_W+1  sample count of current frame; stable from DRAIN entry until next start.
short_frame  out  1  frame truncated by en_adc falling; stable like frame_len.
busy  out  1  high in every state except IDLE.
over_re  out  1  one-cycle pulse when frame fully delivered.

Behaviour:
- Reset (rst_n=0 at clock edge): state IDLE; all outputs 0; internal counters 0. RAM contents are not cleared. Reset mid-capture or mid-drain aborts without over_re.
- IDLE: start=1 -> ARM; clears wr_cnt, skip_cnt, short_frame, frame_len.
- ARM: waits for en_adc=1. Each cycle with en_adc=1 increments skip_cnt; the sample is dropped.
  - When skip_cnt reaches SKIP-1 -> CAPTURE. The next cycle's addata is sample 0.
  - SKIP=0: CAPTURE starts in the first cycle en_adc=1, and that cycle's sample is captured.
  - en_adc falling in ARM resets skip_cnt to 0 and stays in ARM.
- CAPTURE: each cycle with en_adc=1 writes addata to mem[wr_cnt] and increments wr_cnt.
  - Write at wr_cnt=FRAME_LEN-1 -> DRAIN; frame_len=FRAME_LEN.
  - en_adc=0 in CAPTURE: no write; short_frame=1; frame_len=wr_cnt.
    - wr_cnt>0 -> DRAIN.
    - wr_cnt=0 -> DONE; nothing is streamed.
- DRAIN: RAM has 1-cycle registered read; a one-entry output register makes the stream skid-free.
  - First out_valid asserts 2 cycles after DRAIN entry.
  - While out_valid & !out_ready, out_data and out_last hold stable.
  - Full throughput: one byte per cycle when out_ready stays high.
  - out_last=1 exactly with byte index frame_len-1.
  - Acceptance of the last byte -> DONE; out_valid=0 the following cycle.
- DONE: over_re=1 for one cycle -> IDLE. frame_len and short_frame remain held.
- start outside IDLE: ignored, with no side effects.
- Width rules: wr_cnt and rd_cnt are ADDR_W+1 bits so FRAME_LEN is representable. Counters never wrap within a frame.
- en_adc and start are synchronous to clk_32; they are used directly with no synchronizer.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, ARM, CAPTURE, DRAIN, DONE;
  - FRAME_LEN, SKIP and DATA_W defaults, shared with the packetizer header builder.
- One sub-module: capture_ram, a simple dual-port RAM (DATA_W x FRAME_LEN) with synchronous write and registered read, so it infers block RAM.
- FSM, counters and output skid register stay in adc_frame_capture.

Test Plan:
1. Full frame, no backpressure:
   - stimulus: start; en_adc held high; addata = incrementing counter.
   - response: first streamed byte equals the counter value SKIP cycles after en_adc rise; 1024 consecutive bytes; out_last only on byte 1023; frame_len=1024; short_frame=0; over_re single pulse.
2. Backpressure:
   - stimulus: out_ready random 30% low during DRAIN.
   - response: output sequence identical to scenario 1; out_data/out_last unchanged on every cycle with out_valid=1 & out_ready=0; no byte lost or duplicated.
3. Truncated capture:
   - stimulus: en_adc drops after 100 captured samples.
   - response: frame_len=100; short_frame=1; 100 bytes streamed, out_last on byte 99; then over_re.
4. Zero-length frame:
   - stimulus: en_adc drops on the first CAPTURE cycle.
   - response: out_valid never asserts; frame_len=0; short_frame=1; over_re pulses; returns to IDLE.
5. Ignored start:
   - stimulus: extra start pulses during CAPTURE and DRAIN.
   - response: no effect on counters, stream or over_re count (exactly one pulse per accepted start).
6. Reset mid-drain:
   - stimulus: rst_n=0 for one cycle after byte 500 accepted.
   - response: next cycle all outputs 0, busy=0, no over_re; a following start captures and streams a correct full frame.

Source files
------------

// File: rtl/adc_frame_capture_pkg.sv
// rtl/adc_frame_capture_pkg.sv - shared defaults and state encoding for the ADC frame capture path
package adc_frame_capture_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_FRAME_LEN = 1024;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_SKIP      = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port frame RAM, synchronous write, registered read
module capture_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or read register so the tools map this onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_frame_capture.sv
// rtl/adc_frame_capture.sv - captures one ADC frame into RAM and streams it out over valid/ready
module adc_frame_capture
    import adc_frame_capture_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SKIP      = DEF_SKIP
) (
    input  logic              clk_32,
    input  logic              rst_n,
    input  logic              start,
    input  logic              en_adc,
    input  logic [DATA_W-1:0] addata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   frame_len,
    output logic              short_frame,
    output logic              busy,
    output logic              over_re
);

    localparam int                SKIP_W    = (SKIP < 2) ? 1 : $clog2(SKIP);
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W+1)'(FRAME_LEN);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP == 0) ? 0 : SKIP - 1);

    state_t              state, state_next;
    logic [ADDR_W:0]     wr_cnt, rd_cnt;
    logic [SKIP_W-1:0]   skip_cnt;
    logic [DATA_W-1:0]   rd_data;
    logic                mid_valid, mid_last;
    logic                wr_en, rd_en, out_adv, last_accept;

    assign out_adv     = !out_valid || out_ready;
    assign last_accept = out_valid && out_ready && out_last;
    assign busy        = (state != IDLE);
    assign over_re     = (state == DONE);

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (FRAME_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk_32),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (addata),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_32) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (en_adc) begin
                    if (SKIP == 0) begin
                        wr_en      = 1'b1;
                        state_next = (wr_cnt == LAST_IDX) ? DRAIN : CAPTURE;
                    end else if (skip_cnt == SKIP_LAST) begin
                        state_next = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (en_adc) begin
                    wr_en = 1'b1;
                    if (wr_cnt == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end else begin
                    state_next = (wr_cnt != '0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                // Only fetch when the RAM output slot is free or about to move on.
                rd_en = (rd_cnt != frame_len) && (!mid_valid || out_adv);
                if (last_accept) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_32) begin
        if (!rst_n) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            skip_cnt    <= '0;
            frame_len   <= '0;
            short_frame <= 1'b0;
            mid_valid   <= 1'b0;
            mid_last    <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
        end else begin
            if (state == IDLE && start) begin
                wr_cnt      <= '0;
                rd_cnt      <= '0;
                skip_cnt    <= '0;
                frame_len   <= '0;
                short_frame <= 1'b0;
            end

            if (state == ARM) begin
                if (!en_adc) begin
                    skip_cnt <= '0;
                end else if (skip_cnt != SKIP_LAST) begin
                    skip_cnt <= skip_cnt + 1'b1;
                end
            end

            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LAST_IDX) begin
                    frame_len <= FULL_LEN;
                end
            end

            if (state == CAPTURE && !en_adc) begin
                short_frame <= 1'b1;
                frame_len   <= wr_cnt;
            end

            // RAM read register is the first stage, out_* the second; together they absorb a stall.
            if (rd_en) begin
                rd_cnt    <= rd_cnt + 1'b1;
                mid_valid <= 1'b1;
                mid_last  <= ((rd_cnt + 1'b1) == frame_len);
            end else if (out_adv) begin
                mid_valid <= 1'b0;
            end

            if (out_adv) begin
                out_valid <= mid_valid;
                out_last  <= mid_valid && mid_last;
                if (mid_valid) begin
                    out_data <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb/tb_adc_frame_capture.sv - scoreboard bench for adc_frame_capture with a trace-based frame model
module tb_adc_frame_capture;

    localparam int FRAME_LEN = 1024;
    localparam int SKIP      = 4;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } exp_byte_t;

    typedef struct {
        int len;
        bit short_f;
    } exp_frame_t;

    typedef struct {
        bit         en;
        logic [7:0] d;
    } trace_t;

    logic        clk_32 = 1'b0;
    logic        rst_n, start, en_adc, out_ready;
    logic [7:0]  addata, out_data;
    logic        out_valid, out_last, short_frame, busy, over_re;
    logic [10:0] frame_len;

    exp_byte_t  exp_q[$];
    exp_frame_t frame_q[$];
    trace_t     trace[$];

    int n_checks = 0, n_pass = 0;
    int stall_pct = 0, ctr = 0, frame_acc = 0, over_cnt = 0, exp_done = 0;
    int last_len = 0;
    bit last_short = 0;
    bit prev_stall = 0, prev_last = 0, prev_over = 0;
    logic [7:0] prev_data = '0;
    exp_byte_t  mon_b;
    exp_frame_t mon_f;

    always #5 clk_32 = ~clk_32;

    adc_frame_capture dut (
        .clk_32      (clk_32),
        .rst_n       (rst_n),
        .start       (start),
        .en_adc      (en_adc),
        .addata      (addata),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_len   (frame_len),
        .short_frame (short_frame),
        .busy        (busy),
        .over_re     (over_re)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // One driven cycle; every sample is logged so the model can rebuild the frame afterwards.
    task automatic drive_cycle(input bit en, input bit incr, input bit extra);
        en_adc = en;
        addata = incr ? 8'(ctr) : 8'($urandom);
        start  = extra && busy && ($urandom_range(0, 3) == 0);
        trace.push_back('{en, addata});
        ctr++;
        @(posedge clk_32); #1;
    endtask

    // Frame = the first en_adc-high run lasting at least SKIP cycles, minus its first SKIP samples.
    task automatic build_expected();
        int i, j, n;
        bit found, shrt;
        i = 0;
        found = 0;
        while (i < trace.size() && !found) begin
            if (trace[i].en) begin
                j = i;
                while (j < trace.size() && trace[j].en) j++;
                if (j - i >= SKIP) begin
                    n = j - i - SKIP;
                    shrt = (n < FRAME_LEN);
                    if (!shrt) n = FRAME_LEN;
                    for (int k = 0; k < n; k++)
                        exp_q.push_back('{trace[i + SKIP + k].d, (k == n - 1)});
                    frame_q.push_back('{n, shrt});
                    last_len = n;
                    last_short = shrt;
                    found = 1;
                end
                i = j;
            end else begin
                i++;
            end
        end
        if (!found) fail_now("model_no_frame");
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (busy && cnt < 5000) begin
            @(posedge clk_32); #1;
            cnt++;
        end
        if (busy) fail_now("wait_idle");
    endtask

    task automatic capture(input int ncap, input bit incr, input int stall, input bit glitch,
                           input bit extra, input bit do_reset);
        int cnt;
        wait_idle();
        stall_pct = stall;
        trace.delete();
        frame_acc = 0;
        start = 1'b1;
        en_adc = 1'b0;
        @(posedge clk_32); #1;
        start = 1'b0;
        repeat ($urandom_range(0, 3)) drive_cycle(1'b0, incr, extra);
        if (glitch) begin
            repeat ($urandom_range(1, SKIP - 1)) drive_cycle(1'b1, incr, extra);
            repeat ($urandom_range(1, 2)) drive_cycle(1'b0, incr, extra);
        end
        repeat (SKIP + ncap) drive_cycle(1'b1, incr, extra);
        drive_cycle(1'b0, incr, extra);
        start = 1'b0;
        build_expected();

        if (do_reset) begin
            cnt = 0;
            while (frame_acc <= 500 && cnt < 5000) begin
                @(posedge clk_32); #1;
                cnt++;
            end
            if (frame_acc <= 500) fail_now("reset_wait");
            rst_n = 1'b0;
            start = 1'b0;
            @(posedge clk_32); #1;
            rst_n = 1'b1;
            exp_q.delete();
            frame_q.delete();
            check("rst_mid_valid", out_valid, 0);
            check("rst_mid_busy", busy, 0);
            check("rst_mid_over", over_re, 0);
            check("rst_mid_len", frame_len, 0);
            check("rst_mid_short", short_frame, 0);
            check("rst_mid_last", out_last, 0);
            check("rst_mid_data", out_data, 0);
            repeat (3) begin
                @(posedge clk_32); #1;
                check("rst_mid_idle", busy, 0);
            end
        end else begin
            cnt = 0;
            while (busy && cnt < 5000) begin
                start = extra && ($urandom_range(0, 3) == 0);
                @(posedge clk_32); #1;
                cnt++;
            end
            start = 1'b0;
            if (busy) fail_now("frame_done_wait");
            exp_done++;
            @(posedge clk_32); #1;
            check("held_len", frame_len, last_len);
            check("held_short", short_frame, last_short);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk_32); #1;
            out_ready = ($urandom_range(0, 99) >= stall_pct);
        end
    end

    always @(negedge clk_32) begin
        if (!rst_n) begin
            prev_stall = 0;
            prev_over  = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid) check("valid_has_expect", exp_q.size() != 0, 1);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                mon_b = exp_q.pop_front();
                check("data", out_data, mon_b.d);
                check("last", out_last, mon_b.last);
                frame_acc++;
            end
            if (over_re) begin
                check("over_re_single", prev_over, 0);
                check("over_valid_low", out_valid, 0);
                check("over_all_sent", exp_q.size(), 0);
                if (frame_q.size() == 0) begin
                    fail_now("over_re_unexpected");
                end else begin
                    mon_f = frame_q.pop_front();
                    check("frame_len", frame_len, mon_f.len);
                    check("short_frame", short_frame, mon_f.short_f);
                end
                over_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_over  = over_re;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        en_adc = 1'b0;
        addata = '0;
        repeat (3) @(posedge clk_32);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_over", over_re, 0);
        check("reset_len", frame_len, 0);
        check("reset_short", short_frame, 0);
        check("reset_last", out_last, 0);
        check("reset_data", out_data, 0);
        rst_n = 1'b1;
        @(posedge clk_32); #1;

        capture(FRAME_LEN, 1, 0, 0, 0, 0);   // full frame, counter data
        capture(FRAME_LEN, 1, 30, 0, 0, 0);  // backpressure
        capture(100, 0, 20, 0, 0, 0);        // truncated
        capture(0, 0, 0, 0, 0, 0);           // zero length
        capture(300, 0, 30, 1, 1, 0);        // ARM glitch plus ignored starts
        capture(FRAME_LEN, 0, 0, 0, 0, 1);   // reset mid-drain
        capture(FRAME_LEN, 0, 10, 0, 1, 0);  // recovery frame
        for (int r = 0; r < 3; r++)
            capture($urandom_range(1, 200), 0, $urandom_range(0, 50),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        repeat (5) @(posedge clk_32);
        #1;
        check("over_re_count", over_cnt, exp_done);
        check("frames_left", frame_q.size(), 0);
        check("bytes_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
